// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall bundle between the ID-stage decode/pipeline registers and hazard_stall_unit.
// The hazard unit connects through the slave modport; the pipeline side drives through master.
interface hazard_stall_unit_if #(
  parameter int BITS_REGS  = 5,
  parameter int BITS_COUNT = 16
);
  logic [BITS_REGS-1:0]  i_IFID_rs;
  logic [BITS_REGS-1:0]  i_IFID_rt;
  logic                  i_IDEX_mem_read;
  logic                  i_IDEX_reg_write;
  logic [BITS_REGS-1:0]  i_IDEX_rd;
  logic                  i_EXMEM_mem_read;
  logic [BITS_REGS-1:0]  i_EXMEM_rd;
  logic                  i_branch_id;
  logic                  i_jump_taken;
  logic                  i_halt_id;
  logic                  i_dbg_mode;
  logic                  i_dbg_step;
  logic                  o_pc_write;
  logic                  o_IFID_write;
  logic                  o_IFID_flush;
  logic                  o_IDEX_flush;
  logic                  o_pipe_enable;
  logic                  o_halted;
  logic [BITS_COUNT-1:0] o_stall_count;

  modport slave (
    input  i_IFID_rs, i_IFID_rt, i_IDEX_mem_read, i_IDEX_reg_write, i_IDEX_rd,
           i_EXMEM_mem_read, i_EXMEM_rd, i_branch_id, i_jump_taken, i_halt_id,
           i_dbg_mode, i_dbg_step,
    output o_pc_write, o_IFID_write, o_IFID_flush, o_IDEX_flush, o_pipe_enable,
           o_halted, o_stall_count
  );

  modport master (
    output i_IFID_rs, i_IFID_rt, i_IDEX_mem_read, i_IDEX_reg_write, i_IDEX_rd,
           i_EXMEM_mem_read, i_EXMEM_rd, i_branch_id, i_jump_taken, i_halt_id,
           i_dbg_mode, i_dbg_step,
    input  o_pc_write, o_IFID_write, o_IFID_flush, o_IDEX_flush, o_pipe_enable,
           o_halted, o_stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard detection and freeze control for the 5-stage MIPS core: load-use and ID-branch stalls,
// jump flushes, HALT draining and single-step debug gating. Enables/flushes are combinational.
module hazard_stall_unit #(
  parameter int BITS_REGS    = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int BITS_COUNT   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  hazard_stall_unit_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      drain_q, drain_d;
  logic [BITS_COUNT-1:0] stall_cnt_q;
  logic                  stall_inc;

  logic en, lu, br_ex, br_mem, stall;
  logic pc_write, ifid_write, ifid_flush, idex_flush, pipe_enable;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [BITS_REGS-1:0] x,
                                     input logic [BITS_REGS-1:0] rs,
                                     input logic [BITS_REGS-1:0] rt);
    return (x != '0) && ((x == rs) || (x == rt));
  endfunction

  function automatic logic [BITS_COUNT-1:0] sat_inc(input logic [BITS_COUNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    en     = !bus.i_dbg_mode || bus.i_dbg_step;
    lu     = bus.i_IDEX_mem_read && reg_match(bus.i_IDEX_rd, bus.i_IFID_rs, bus.i_IFID_rt);
    br_ex  = bus.i_branch_id && bus.i_IDEX_reg_write &&
             reg_match(bus.i_IDEX_rd, bus.i_IFID_rs, bus.i_IFID_rt);
    br_mem = bus.i_branch_id && bus.i_EXMEM_mem_read &&
             reg_match(bus.i_EXMEM_rd, bus.i_IFID_rs, bus.i_IFID_rt);
    stall  = lu || br_ex || br_mem;
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_inc   = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_enable = 1'b0;
    if (i_reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            pipe_enable = 1'b1;
            if (stall) begin
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
            end else if (bus.i_halt_id) begin
              idex_flush = 1'b1;
              state_d    = DRAIN;
              drain_d    = CNT_W'(DRAIN_CYCLES - 1);
            end else if (bus.i_jump_taken) begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              ifid_flush = 1'b1;
            end else begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
            end
          end
        end
        DRAIN: begin
          // Bubbles push EX/MEM/WB empty; the count only advances on cycles the pipe moves.
          if (en) begin
            pipe_enable = 1'b1;
            idex_flush  = 1'b1;
            if (drain_q == '0) state_d = HALTED;
            else               drain_d = drain_q - 1'b1;
          end
        end
        HALTED: ;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.o_pc_write    = pc_write;
  assign bus.o_IFID_write  = ifid_write;
  assign bus.o_IFID_flush  = ifid_flush;
  assign bus.o_IDEX_flush  = idex_flush;
  assign bus.o_pipe_enable = pipe_enable;
  assign bus.o_halted      = (state_q == HALTED);
  assign bus.o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed pipeline scenarios plus random traffic checked
// against a cycle-level model of the stall/drain/halt rules.
module tb_hazard_stall_unit;
  localparam int BR   = 5;
  localparam int DC   = 3;
  localparam int BC   = 8;
  localparam int OW   = 6 + BC;
  localparam int CMAX = (1 << BC) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  hazard_stall_unit_if #(.BITS_REGS(BR), .BITS_COUNT(BC)) bus ();

  hazard_stall_unit #(.BITS_REGS(BR), .DRAIN_CYCLES(DC), .BITS_COUNT(BC)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state: halted flag, bubbles still owed by a HALT drain, saturating stall count.
  bit m_halted;
  int m_drain;
  int m_count;

  wire [OW-1:0] outs = {bus.o_pc_write, bus.o_IFID_write, bus.o_IFID_flush, bus.o_IDEX_flush,
                        bus.o_pipe_enable, bus.o_halted, bus.o_stall_count};

  function automatic bit uses(input int x);
    int rs = int'(bus.i_IFID_rs);
    int rt = int'(bus.i_IFID_rt);
    return (x != 0) && (x == rs || x == rt);
  endfunction

  function automatic bit m_stall();
    return (bus.i_IDEX_mem_read && uses(int'(bus.i_IDEX_rd))) ||
           (bus.i_branch_id && bus.i_IDEX_reg_write && uses(int'(bus.i_IDEX_rd))) ||
           (bus.i_branch_id && bus.i_EXMEM_mem_read && uses(int'(bus.i_EXMEM_rd)));
  endfunction

  function automatic bit m_en();
    return !bus.i_dbg_mode || bus.i_dbg_step;
  endfunction

  // Expected {pc_write, IFID_write, IFID_flush, IDEX_flush, pipe_enable}.
  function automatic logic [OW-1:0] exp_out();
    logic [4:0] c;
    if (rst)                 c = 5'b00110;
    else if (m_halted)       c = 5'b00000;
    else if (!m_en())        c = 5'b00000;
    else if (m_drain > 0)    c = 5'b00011;
    else if (m_stall())      c = 5'b00011;
    else if (bus.i_halt_id)  c = 5'b00011;
    else if (bus.i_jump_taken) c = 5'b11101;
    else                     c = 5'b11001;
    return {c, m_halted, BC'(m_count)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_halted = 0; m_drain = 0; m_count = 0;
    end else if (!m_halted && m_en()) begin
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (m_stall()) begin
        if (m_count < CMAX) m_count++;
      end else if (bus.i_halt_id) begin
        m_drain = DC;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    bus.i_IFID_rs = '0; bus.i_IFID_rt = '0;
    bus.i_IDEX_mem_read = 0; bus.i_IDEX_reg_write = 0; bus.i_IDEX_rd = '0;
    bus.i_EXMEM_mem_read = 0; bus.i_EXMEM_rd = '0;
    bus.i_branch_id = 0; bus.i_jump_taken = 0; bus.i_halt_id = 0;
    bus.i_dbg_mode = 0; bus.i_dbg_step = 0;
  endtask

  task automatic set_random(input int halt_pct);
    bus.i_IFID_rs        = BR'($urandom_range(0, 3));
    bus.i_IFID_rt        = BR'($urandom_range(0, 3));
    bus.i_IDEX_mem_read  = 1'($urandom_range(0, 3) == 0);
    bus.i_IDEX_reg_write = 1'($urandom_range(0, 1));
    bus.i_IDEX_rd        = BR'($urandom_range(0, 3));
    bus.i_EXMEM_mem_read = 1'($urandom_range(0, 3) == 0);
    bus.i_EXMEM_rd       = BR'($urandom_range(0, 3));
    bus.i_branch_id      = 1'($urandom_range(0, 2) == 0);
    bus.i_jump_taken     = 1'($urandom_range(0, 3) == 0);
    bus.i_halt_id        = 1'($urandom_range(0, 99) < halt_pct);
    bus.i_dbg_mode       = 1'($urandom_range(0, 3) == 0);
    bus.i_dbg_step       = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    set_random(50);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_random(50);
      @(negedge clk);
      checks++;
      if (outs !== {5'b00110, 1'b0, BC'(0)} || outs !== exp_out()) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.i_IDEX_mem_read = 1; bus.i_IDEX_reg_write = 1; bus.i_IDEX_rd = BR'(2);
    bus.i_IFID_rs = BR'(2); bus.i_IFID_rt = BR'(7);
    @(negedge clk);
    checks++;
    if (bus.o_pc_write !== 1'b0 || bus.o_IDEX_flush !== 1'b1 || bus.o_IFID_write !== 1'b0 ||
        bus.o_stall_count !== BC'(0) || outs !== exp_out()) begin
      errors++;
      $display("FAIL load_use_stall got %h want %h", outs, exp_out());
    end
    tick();
    bus.i_IDEX_mem_read = 0; bus.i_IDEX_reg_write = 0; bus.i_IDEX_rd = '0;
    bus.i_EXMEM_mem_read = 1; bus.i_EXMEM_rd = BR'(2);
    @(negedge clk);
    checks++;
    if (bus.o_pc_write !== 1'b1 || bus.o_IDEX_flush !== 1'b0 || bus.o_stall_count !== BC'(1) ||
        outs !== exp_out()) begin
      errors++;
      $display("FAIL load_use_release got %h want %h", outs, exp_out());
    end
    tick();
  endtask

  task automatic test_load_branch();
    do_reset();
    bus.i_branch_id = 1; bus.i_IFID_rs = BR'(5); bus.i_IFID_rt = BR'(3);
    bus.i_IDEX_mem_read = 1; bus.i_IDEX_reg_write = 1; bus.i_IDEX_rd = BR'(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_pc_write !== 1'b0 || bus.o_IDEX_flush !== 1'b1 || outs !== exp_out()) begin
        errors++;
        $display("FAIL load_branch_stall%0d got %h want %h", i, outs, exp_out());
      end
      tick();
      // The load moves to MEM; a bubble now sits in EX.
      bus.i_IDEX_mem_read = 0; bus.i_IDEX_reg_write = 0; bus.i_IDEX_rd = '0;
      bus.i_EXMEM_mem_read = (i == 0); bus.i_EXMEM_rd = BR'(3);
    end
    bus.i_jump_taken = 1;
    @(negedge clk);
    checks++;
    if (bus.o_stall_count !== BC'(2) || bus.o_pc_write !== 1'b1 || bus.o_IFID_flush !== 1'b1 ||
        outs !== exp_out()) begin
      errors++;
      $display("FAIL load_branch_resolve got %h want %h", outs, exp_out());
    end
    tick();
    // ALU result feeding a branch: one stall only.
    set_idle();
    bus.i_branch_id = 1; bus.i_IFID_rs = BR'(4); bus.i_IDEX_reg_write = 1; bus.i_IDEX_rd = BR'(4);
    @(negedge clk);
    checks++;
    if (bus.o_pc_write !== 1'b0 || bus.o_stall_count !== BC'(2) || outs !== exp_out()) begin
      errors++;
      $display("FAIL alu_branch_stall got %h want %h", outs, exp_out());
    end
    tick();
    bus.i_IDEX_reg_write = 0; bus.i_IDEX_rd = '0;
    @(negedge clk);
    checks++;
    if (bus.o_pc_write !== 1'b1 || bus.o_stall_count !== BC'(3) || outs !== exp_out()) begin
      errors++;
      $display("FAIL alu_branch_release got %h want %h", outs, exp_out());
    end
    tick();
  endtask

  task automatic test_zero_reg_jump();
    do_reset();
    bus.i_IDEX_mem_read = 1; bus.i_IDEX_reg_write = 1; bus.i_IDEX_rd = '0;
    bus.i_EXMEM_mem_read = 1; bus.i_EXMEM_rd = '0; bus.i_branch_id = 1;
    @(negedge clk);
    checks++;
    if (outs !== {5'b11001, 1'b0, BC'(0)} || outs !== exp_out()) begin
      errors++;
      $display("FAIL zero_reg_no_stall got %h want %h", outs, exp_out());
    end
    tick();
    set_idle();
    bus.i_jump_taken = 1;
    @(negedge clk);
    checks++;
    if (outs !== {5'b11101, 1'b0, BC'(0)} || outs !== exp_out()) begin
      errors++;
      $display("FAIL jump_flush got %h want %h", outs, exp_out());
    end
    tick();
    bus.i_jump_taken = 0;
    @(negedge clk);
    checks++;
    if (bus.o_IFID_flush !== 1'b0 || outs !== exp_out()) begin
      errors++;
      $display("FAIL jump_flush_one_cycle got %h want %h", outs, exp_out());
    end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    bus.i_halt_id = 1;
    @(negedge clk);
    checks++;
    if (outs !== {5'b00011, 1'b0, BC'(0)} || outs !== exp_out()) begin
      errors++;
      $display("FAIL halt_accept got %h want %h", outs, exp_out());
    end
    tick();
    for (int i = 0; i < DC; i++) begin
      set_random(0);
      bus.i_dbg_mode = 0;
      @(negedge clk);
      checks++;
      if (outs[OW-1 -: 6] !== 6'b000110 || outs !== exp_out()) begin
        errors++;
        $display("FAIL halt_drain%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_random(50);
      @(negedge clk);
      checks++;
      if (outs[OW-1 -: 6] !== 6'b000001 || outs !== exp_out()) begin
        errors++;
        $display("FAIL halted%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.o_halted !== 1'b1 || bus.o_IDEX_flush !== 1'b1 || bus.o_pc_write !== 1'b0) begin
      errors++;
      $display("FAIL halted_before_reset_edge got %h", outs);
    end
    tick();
    rst = 0;
    set_idle();
    @(negedge clk);
    checks++;
    if (bus.o_halted !== 1'b0 || bus.o_pc_write !== 1'b1 || outs !== exp_out()) begin
      errors++;
      $display("FAIL halt_reset_exit got %h want %h", outs, exp_out());
    end
    tick();
  endtask

  task automatic test_dbg();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_random(0);
      bus.i_dbg_mode = 1; bus.i_dbg_step = 0;
      @(negedge clk);
      checks++;
      if (outs[OW-1 -: 5] !== 5'b00000 || outs !== exp_out()) begin
        errors++;
        $display("FAIL dbg_frozen%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    set_idle();
    bus.i_dbg_mode = 1; bus.i_dbg_step = 1;
    @(negedge clk);
    checks++;
    if (outs[OW-1 -: 5] !== 5'b11001 || outs !== exp_out()) begin
      errors++;
      $display("FAIL dbg_step_advance got %h want %h", outs, exp_out());
    end
    tick();
    bus.i_dbg_step = 0;
    bus.i_IDEX_mem_read = 1; bus.i_IDEX_rd = BR'(6); bus.i_IFID_rt = BR'(6);
    for (int i = 0; i < 3; i++) begin
      bus.i_dbg_step = (i == 2);
      @(negedge clk);
      checks++;
      if (bus.o_IDEX_flush !== (i == 2) || bus.o_pc_write !== 1'b0 ||
          bus.o_stall_count !== BC'(0) || outs !== exp_out()) begin
        errors++;
        $display("FAIL dbg_load_use%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    bus.i_dbg_step = 0;
    @(negedge clk);
    checks++;
    if (bus.o_stall_count !== BC'(1) || outs !== exp_out()) begin
      errors++;
      $display("FAIL dbg_stall_count got %h want %h", outs, exp_out());
    end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    bus.i_IDEX_mem_read = 1; bus.i_IDEX_rd = BR'(9); bus.i_IFID_rs = BR'(9);
    for (int i = 0; i < CMAX + 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp_out()) begin
        errors++;
        $display("FAIL sat_cycle%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.o_stall_count !== BC'(CMAX)) begin
      errors++;
      $display("FAIL sat_value got %h want %h", bus.o_stall_count, BC'(CMAX));
    end
    do_reset();
    bus.i_IDEX_mem_read = 1; bus.i_IDEX_rd = BR'(9); bus.i_IFID_rs = BR'(9);
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.o_stall_count !== BC'(0) || outs !== exp_out()) begin
      errors++;
      $display("FAIL count_reset got %h want %h", outs, exp_out());
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_random(8);
      rst = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      checks++;
      if (outs !== exp_out()) begin
        errors++;
        $display("FAIL random%0d got %h want %h", i, outs, exp_out());
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    set_idle();
    m_halted = 0; m_drain = 0; m_count = 0;
    test_reset();
    test_load_use();
    test_load_branch();
    test_zero_reg_jump();
    test_halt();
    test_dbg();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
